pcie_us_rq_arbiter: RTL and testbench

//   Packet-granular round-robin arbiter sharing the UltraScale requester-request (RQ) AXI-stream

---
 rtl/pcie_us_rq_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_pcie_us_rq_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_rq_arbiter.sv
// -----------------------------------------------------------------------------
// pcie_us_rq_arbiter
//   Packet-granular round-robin arbiter that shares the UltraScale requester
//   request (RQ) AXI-stream between PORTS independent requesters. A grant is
//   held from the first beat until the tlast beat is accepted, so TLPs never
//   interleave. The outgoing stream is fully registered.
//
// Ports
//   user_clk          core user clock, all logic on the rising edge
//   user_reset_n      synchronous reset, active low
//   s_req_tdata       requester data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_req_tkeep       requester dword keep
//   s_req_tlast       requester end of TLP
//   s_req_tuser       requester RQ sideband
//   s_req_tvalid      requester beat valid
//   s_req_tready      requester beat accepted (only the granted port, ACTIVE only)
//   m_axis_rq_*       registered stream to the core s_axis_rq interface
//   m_axis_rq_tready  core ready; only bit 0 is used
//   grant_port        index of the port currently / last granted
//   busy              high while a packet grant is held (ACTIVE)
// -----------------------------------------------------------------------------
module pcie_us_rq_arbiter #(
    parameter int PORTS         = 2,
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 32,
    parameter int RQ_USER_WIDTH = 60,
    parameter int CL_PORTS      = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                          user_clk,
    input  logic                          user_reset_n,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_req_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]   s_req_tkeep,
    input  logic [PORTS-1:0]              s_req_tlast,
    input  logic [PORTS*RQ_USER_WIDTH-1:0] s_req_tuser,
    input  logic [PORTS-1:0]              s_req_tvalid,
    output logic [PORTS-1:0]              s_req_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_rq_tkeep,
    output logic                          m_axis_rq_tlast,
    output logic [RQ_USER_WIDTH-1:0]      m_axis_rq_tuser,
    output logic                          m_axis_rq_tvalid,
    input  logic [3:0]                    m_axis_rq_tready,
    output logic [CL_PORTS-1:0]           grant_port,
    output logic                          busy
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CL_PORTS-1:0]        r_grant;

    logic [DATA_WIDTH-1:0]      r_tdata;
    logic [KEEP_WIDTH-1:0]      r_tkeep;
    logic                       r_tlast;
    logic [RQ_USER_WIDTH-1:0]   r_tuser;
    logic                       r_tvalid;

    logic [DATA_WIDTH-1:0]      w_sel_tdata;
    logic [KEEP_WIDTH-1:0]      w_sel_tkeep;
    logic                       w_sel_tlast;
    logic [RQ_USER_WIDTH-1:0]   w_sel_tuser;
    logic                       w_sel_tvalid;

    logic                       w_arb_found;
    logic [CL_PORTS-1:0]        w_arb_idx;
    logic                       w_out_ready;
    logic                       w_accept;

    // Upper ready bits from the core carry no meaning for this arbiter.
    logic                       w_unused_tready;
    assign w_unused_tready = ^m_axis_rq_tready[3:1];

    // Output register may take a new beat when empty or draining this cycle.
    assign w_out_ready = ~r_tvalid | m_axis_rq_tready[0];
    assign w_accept    = (r_state == S_ACTIVE) & w_out_ready & w_sel_tvalid;

    // Mux of the granted port's stream.
    always_comb begin
        w_sel_tdata  = '0;
        w_sel_tkeep  = '0;
        w_sel_tlast  = 1'b0;
        w_sel_tuser  = '0;
        w_sel_tvalid = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (r_grant == CL_PORTS'(p)) begin
                w_sel_tdata  = s_req_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                w_sel_tkeep  = s_req_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
                w_sel_tlast  = s_req_tlast[p];
                w_sel_tuser  = s_req_tuser[p*RQ_USER_WIDTH +: RQ_USER_WIDTH];
                w_sel_tvalid = s_req_tvalid[p];
            end
        end
    end

    // Round-robin search starting one past the last grant; the last granted
    // port is checked last, giving it lowest priority for the next packet.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = r_grant;
        for (int i = 1; i <= PORTS; i++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (!w_arb_found && (p == ((int'(r_grant) + i) % PORTS)) && s_req_tvalid[p]) begin
                    w_arb_found = 1'b1;
                    w_arb_idx   = CL_PORTS'(p);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_arb_found) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_accept && w_sel_tlast) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: only the granted port sees ready, and only while ACTIVE.
    always_comb begin
        s_req_tready = '0;
        busy         = 1'b0;
        if (r_state == S_ACTIVE) begin
            busy = 1'b1;
            for (int p = 0; p < PORTS; p++) begin
                if (r_grant == CL_PORTS'(p)) s_req_tready[p] = w_out_ready;
            end
        end
    end

    // Grant register: reset to the last port so port 0 wins first.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            r_grant <= CL_PORTS'(PORTS - 1);
        end else if ((r_state == S_IDLE) && w_arb_found) begin
            r_grant <= w_arb_idx;
        end
    end

    // Output register: holds the beat while the core stalls.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= '0;
            r_tvalid <= 1'b0;
        end else if (w_accept) begin
            r_tdata  <= w_sel_tdata;
            r_tkeep  <= w_sel_tkeep;
            r_tlast  <= w_sel_tlast;
            r_tuser  <= w_sel_tuser;
            r_tvalid <= 1'b1;
        end else if (m_axis_rq_tready[0]) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_rq_tdata  = r_tdata;
    assign m_axis_rq_tkeep  = r_tkeep;
    assign m_axis_rq_tlast  = r_tlast;
    assign m_axis_rq_tuser  = r_tuser;
    assign m_axis_rq_tvalid = r_tvalid;
    assign grant_port       = r_grant;

endmodule

// File: tb/tb_pcie_us_rq_arbiter.sv
module tb_pcie_us_rq_arbiter;

    localparam int PORTS = 2;
    localparam int DW    = 64;
    localparam int KW    = DW / 32;
    localparam int UW    = 60;
    localparam int NPKT  = 12;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [PORTS*DW-1:0]   s_tdata;
    logic [PORTS*KW-1:0]   s_tkeep;
    logic [PORTS-1:0]      s_tlast;
    logic [PORTS*UW-1:0]   s_tuser;
    logic [PORTS-1:0]      s_tvalid;
    logic [PORTS-1:0]      s_tready;
    logic [DW-1:0]         m_tdata;
    logic [KW-1:0]         m_tkeep;
    logic                  m_tlast;
    logic [UW-1:0]         m_tuser;
    logic                  m_tvalid;
    logic [3:0]            m_tready;
    logic [0:0]            grant;
    logic                  busy;

    always #5 clk = ~clk;

    pcie_us_rq_arbiter #(
        .PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .RQ_USER_WIDTH(UW), .CL_PORTS(1)
    ) dut (
        .user_clk(clk), .user_reset_n(rst_n),
        .s_req_tdata(s_tdata), .s_req_tkeep(s_tkeep), .s_req_tlast(s_tlast),
        .s_req_tuser(s_tuser), .s_req_tvalid(s_tvalid), .s_req_tready(s_tready),
        .m_axis_rq_tdata(m_tdata), .m_axis_rq_tkeep(m_tkeep), .m_axis_rq_tlast(m_tlast),
        .m_axis_rq_tuser(m_tuser), .m_axis_rq_tvalid(m_tvalid), .m_axis_rq_tready(m_tready),
        .grant_port(grant), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  l;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rdy;
        logic        etv;
        logic        etl;
        logic [31:0] ed;
        logic [1:0]  esr;
        logic        eg;
        logic        eb;
    } vec_t;

    vec_t tbl[36];

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic [31:0] d0,
                                input logic [31:0] d1, input logic rdy, input logic etv,
                                input logic etl, input logic [31:0] ed, input logic [1:0] esr,
                                input logic eg, input logic eb);
        vec_t r;
        r.v = v; r.l = l; r.d0 = d0; r.d1 = d1; r.rdy = rdy;
        r.etv = etv; r.etl = etl; r.ed = ed; r.esr = esr; r.eg = eg; r.eb = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beat encoding: keep = d[1:0], tuser = ~d, so passthrough of all fields is visible.
    task automatic drive(input int p, input logic v, input logic l, input logic [31:0] d);
        s_tvalid[p]         = v;
        s_tlast[p]          = l;
        s_tdata[p*DW +: DW] = {32'h0, d};
        s_tkeep[p*KW +: KW] = d[1:0];
        s_tuser[p*UW +: UW] = {28'h0, ~d};
    endtask

    task automatic check_out(input string tag, input logic etv, input logic etl,
                             input logic [31:0] ed, input logic [1:0] esr,
                             input logic eg, input logic eb);
        check({tag, ".tvalid"}, m_tvalid, etv);
        check({tag, ".s_tready"}, s_tready, esr);
        check({tag, ".grant"}, grant, eg);
        check({tag, ".busy"}, busy, eb);
        if (etv) begin
            check({tag, ".tlast"}, m_tlast, etl);
            check({tag, ".tdata"}, m_tdata, {32'h0, ed});
            check({tag, ".tkeep"}, m_tkeep, ed[1:0]);
            check({tag, ".tuser"}, m_tuser, {28'h0, ~ed});
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int pkt[2], beat[2], len[2], exp_pkt[2], exp_beat[2];
    int cur_port, rx, cyc, gv, op, opk, ob, ol;
    logic acc[2];
    logic ok;

    initial begin
        // Tests 2..5: single packet, alternating packets, stall, bubbles.
        tbl[0]  = mk(2'b01, 2'b00, 32'hA001, 32'h0,    1, 0, 0, 32'h0,    2'b00, 1, 0);
        tbl[1]  = mk(2'b01, 2'b00, 32'hA001, 32'h0,    1, 0, 0, 32'h0,    2'b01, 0, 1);
        tbl[2]  = mk(2'b01, 2'b00, 32'hA002, 32'h0,    1, 1, 0, 32'hA001, 2'b01, 0, 1);
        tbl[3]  = mk(2'b01, 2'b01, 32'hA003, 32'h0,    1, 1, 0, 32'hA002, 2'b01, 0, 1);
        tbl[4]  = mk(2'b00, 2'b00, 32'h0,    32'h0,    1, 1, 1, 32'hA003, 2'b00, 0, 0);
        tbl[5]  = mk(2'b00, 2'b00, 32'h0,    32'h0,    1, 0, 0, 32'h0,    2'b00, 0, 0);
        tbl[6]  = mk(2'b11, 2'b00, 32'hA004, 32'hB001, 1, 0, 0, 32'h0,    2'b00, 0, 0);
        tbl[7]  = mk(2'b11, 2'b00, 32'hA004, 32'hB001, 1, 0, 0, 32'h0,    2'b10, 1, 1);
        tbl[8]  = mk(2'b11, 2'b10, 32'hA004, 32'hB002, 1, 1, 0, 32'hB001, 2'b10, 1, 1);
        tbl[9]  = mk(2'b11, 2'b00, 32'hA004, 32'hB003, 1, 1, 1, 32'hB002, 2'b00, 1, 0);
        tbl[10] = mk(2'b11, 2'b00, 32'hA004, 32'hB003, 1, 0, 0, 32'h0,    2'b01, 0, 1);
        tbl[11] = mk(2'b11, 2'b01, 32'hA005, 32'hB003, 1, 1, 0, 32'hA004, 2'b01, 0, 1);
        tbl[12] = mk(2'b11, 2'b00, 32'hA006, 32'hB003, 1, 1, 1, 32'hA005, 2'b00, 0, 0);
        tbl[13] = mk(2'b11, 2'b00, 32'hA006, 32'hB003, 1, 0, 0, 32'h0,    2'b10, 1, 1);
        tbl[14] = mk(2'b11, 2'b10, 32'hA006, 32'hB004, 1, 1, 0, 32'hB003, 2'b10, 1, 1);
        tbl[15] = mk(2'b00, 2'b00, 32'h0,    32'h0,    1, 1, 1, 32'hB004, 2'b00, 1, 0);
        tbl[16] = mk(2'b01, 2'b00, 32'hA007, 32'h0,    1, 0, 0, 32'h0,    2'b00, 1, 0);
        tbl[17] = mk(2'b01, 2'b00, 32'hA007, 32'h0,    1, 0, 0, 32'h0,    2'b01, 0, 1);
        for (int k = 18; k <= 22; k++)
            tbl[k] = mk(2'b01, 2'b00, 32'hA008, 32'h0, 0, 1, 0, 32'hA007, 2'b00, 0, 1);
        tbl[23] = mk(2'b01, 2'b00, 32'hA008, 32'h0,    1, 1, 0, 32'hA007, 2'b01, 0, 1);
        tbl[24] = mk(2'b01, 2'b01, 32'hA009, 32'h0,    1, 1, 0, 32'hA008, 2'b01, 0, 1);
        tbl[25] = mk(2'b00, 2'b00, 32'h0,    32'h0,    1, 1, 1, 32'hA009, 2'b00, 0, 0);
        tbl[26] = mk(2'b01, 2'b00, 32'hA00A, 32'h0,    1, 0, 0, 32'h0,    2'b00, 0, 0);
        tbl[27] = mk(2'b01, 2'b00, 32'hA00A, 32'h0,    1, 0, 0, 32'h0,    2'b01, 0, 1);
        tbl[28] = mk(2'b10, 2'b10, 32'h0,    32'hB005, 1, 1, 0, 32'hA00A, 2'b01, 0, 1);
        tbl[29] = mk(2'b10, 2'b10, 32'h0,    32'hB005, 1, 0, 0, 32'h0,    2'b01, 0, 1);
        tbl[30] = mk(2'b10, 2'b10, 32'h0,    32'hB005, 1, 0, 0, 32'h0,    2'b01, 0, 1);
        tbl[31] = mk(2'b11, 2'b11, 32'hA00B, 32'hB005, 1, 0, 0, 32'h0,    2'b01, 0, 1);
        tbl[32] = mk(2'b10, 2'b10, 32'h0,    32'hB005, 1, 1, 1, 32'hA00B, 2'b00, 0, 0);
        tbl[33] = mk(2'b10, 2'b10, 32'h0,    32'hB005, 1, 0, 0, 32'h0,    2'b10, 1, 1);
        tbl[34] = mk(2'b00, 2'b00, 32'h0,    32'h0,    1, 1, 1, 32'hB005, 2'b00, 1, 0);
        tbl[35] = mk(2'b00, 2'b00, 32'h0,    32'h0,    1, 0, 0, 32'h0,    2'b00, 1, 0);

        // Test 1: reset held with every requester valid.
        rst_n    = 1'b0;
        m_tready = 4'b0001;
        drive(0, 1'b1, 1'b0, 32'h5A5A);
        drive(1, 1'b1, 1'b0, 32'h6B6B);
        for (int k = 0; k < 3; k++) next_cycle();
        #4;
        check_out("reset", 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
        check("reset.tdata", m_tdata, 64'h0);
        check("reset.tuser", m_tuser, 64'h0);
        next_cycle();

        for (int k = 0; k < 36; k++) begin
            rst_n = 1'b1;
            drive(0, tbl[k].v[0], tbl[k].l[0], tbl[k].d0);
            drive(1, tbl[k].v[1], tbl[k].l[1], tbl[k].d1);
            m_tready = {3'b110, tbl[k].rdy};
            #4;
            check_out($sformatf("row%0d", k), tbl[k].etv, tbl[k].etl, tbl[k].ed,
                      tbl[k].esr, tbl[k].eg, tbl[k].eb);
            next_cycle();
        end

        // Test 6: reset pulse in the middle of a packet.
        m_tready = 4'b0001;
        drive(0, 1'b1, 1'b0, 32'hC001);
        drive(1, 1'b1, 1'b0, 32'hD001);
        #4;
        check_out("mrst.arb", 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
        next_cycle();
        #4;
        check_out("mrst.grant", 1'b0, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        #4;
        check("mrst.beat.tvalid", m_tvalid, 1'b1);
        check("mrst.beat.tdata", m_tdata, 64'hC001);
        next_cycle();
        rst_n = 1'b1;
        #4;
        check_out("mrst.after", 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        #4;
        check_out("mrst.regrant", 1'b0, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;

        // Randomized soak: per-port packet/beat numbering checked at the output.
        for (int p = 0; p < 2; p++) begin
            pkt[p] = 0; beat[p] = 0; len[p] = $urandom_range(1, 4);
            exp_pkt[p] = 0; exp_beat[p] = 0;
        end
        cur_port = -1;
        rx = 0;
        for (cyc = 0; cyc < 4000 && rx < 2 * NPKT; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                gv = ((pkt[p] < NPKT) && ($urandom_range(0, 3) != 0)) ? 1 : 0;
                drive(p, gv != 0, beat[p] == len[p] - 1,
                      {4'(p), 12'(pkt[p]), 8'(beat[p]), 8'(len[p])});
            end
            m_tready = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0)};
            #4;
            for (int p = 0; p < 2; p++) acc[p] = s_tvalid[p] & s_tready[p];
            if (m_tvalid && m_tready[0]) begin
                op  = int'(m_tdata[31:28]);
                opk = int'(m_tdata[27:16]);
                ob  = int'(m_tdata[15:8]);
                ol  = int'(m_tdata[7:0]);
                ok  = 1'b0;
                if (op < 2 && (cur_port < 0 || cur_port == op))
                    ok = (opk == exp_pkt[op]) && (ob == exp_beat[op]) &&
                         (m_tlast == (ob == ol - 1)) &&
                         (m_tuser == {28'h0, ~m_tdata[31:0]}) && (m_tkeep == m_tdata[1:0]);
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL soak.beat: got port %0d pkt %0d beat %0d tlast %0b, cur_port %0d",
                             op, opk, ob, m_tlast, cur_port);
                end
                if (op < 2) begin
                    if (m_tlast) begin
                        cur_port = -1; exp_pkt[op]++; exp_beat[op] = 0; rx++;
                    end else begin
                        cur_port = op; exp_beat[op]++;
                    end
                end
            end
            next_cycle();
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    beat[p]++;
                    if (beat[p] == len[p]) begin
                        beat[p] = 0; pkt[p]++; len[p] = $urandom_range(1, 4);
                    end
                end
            end
        end
        check("soak.packets", rx, 2 * NPKT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
